// File: rtl/alu_share_pkg.sv
// Shared types and constants for the shared-ALU arbiter.
// Opcodes, FSM states and datapath width.
package alu_share_pkg;

  localparam int DW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu4.sv
// Team 4-bit combinational ALU.
// Illegal opcodes raise err and yield zero.
module alu4
  import alu_share_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] y,
  output logic          err
);

  // Decode opcode; add/sub wrap modulo 16
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts at ptr and wraps; one-hot grant plus index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id
);

  logic found;
  int   idx;

  // First requester at or after ptr wins
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NREQ requesters.
// Round-robin grant, capture, execute, registered tagged response.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_a,
  input  logic [NREQ*4-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [DW-1:0]     rsp_result,
  output logic              rsp_err
);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gid;
  logic [NREQ-1:0] gnt;
  logic            arb_en;
  logic            hs;
  logic [DW-1:0]   cap_a;
  logic [DW-1:0]   cap_b;
  logic [2:0]      cap_op;
  logic [IDW-1:0]  cap_id;
  logic [DW-1:0]   alu_y;
  logic            alu_err;

  // Grants only in IDLE and never while reset is held
  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt),
    .id  (gid)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;
  assign rsp_valid = (state == RESP);

  alu4 u_alu (
    .a   (cap_a),
    .b   (cap_b),
    .op  (cap_op),
    .y   (alu_y),
    .err (alu_err)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture granted payload; advance pointer past winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_a  <= '0;
      cap_b  <= '0;
      cap_op <= '0;
      cap_id <= '0;
      ptr    <= '0;
    end else if (hs) begin
      cap_a  <= req_a[int'(gid)*4 +: 4];
      cap_b  <= req_b[int'(gid)*4 +: 4];
      cap_op <= req_op[int'(gid)*3 +: 3];
      cap_id <= gid;
      ptr    <= (gid == IDW'(NREQ-1))
                ? '0 : gid + 1'b1;
    end
  end

  // Register the ALU outcome; held through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= cap_id;
      rsp_result <= alu_err ? '0 : alu_y;
      rsp_err    <= alu_err;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: random and directed stimulus,
// reference arbiter/ALU model, response scoreboard.
module tb_alu_share_arbiter;

  localparam int N = 2;
  localparam int IW = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*4-1:0] req_a;
  logic [N*4-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [3:0]     rsp_result;
  logic           rsp_err;

  alu_share_arbiter #(.NREQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // Requester-side model state
  logic [3:0] pa [N];
  logic [3:0] pb [N];
  logic [2:0] po [N];
  logic [N-1:0] pv;
  logic [N-1:0] gdone;

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4]  = pa[i];
      req_b[4*i +: 4]  = pb[i];
      req_op[3*i +: 3] = po[i];
    end
  end
  assign req_valid = pv;

  typedef struct {
    int         id;
    logic [3:0] res;
    logic       err;
    int         due;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ptr_m = 0;
  bit   busy = 0;
  bit   shown = 0;
  bit   gapchk = 0;
  int   last_g = -1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(int id, int a, int b,
                                  int op, int due);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    e.due = due;
    case (op)
      0:       e.res = 4'((a + b) % 16);
      1:       e.res = 4'((a - b + 16) % 16);
      2:       e.res = 4'(a & b);
      3:       e.res = 4'(a | b);
      default: begin e.res = 4'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: arbitration model + response scoreboard
  always @(negedge clk) begin
    int eid;
    exp_t e;
    if (!rst) begin
      cyc++;
      if (!busy) begin
        eid = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (ptr_m + k) % N;
          if (eid < 0 && req_valid[idx]) eid = idx;
        end
        if (eid >= 0) begin
          chk("grant", 32'(req_ready), 32'(1) << eid);
          if (req_ready[eid]) gdone[eid] = 1'b1;
          e = ref_op(eid, int'(pa[eid]), int'(pb[eid]),
                     int'(po[eid]), cyc + 2);
          sbq.push_back(e);
          ptr_m = (eid + 1) % N;
          busy = 1'b1;
          if (gapchk && last_g >= 0)
            chk("grant_gap", cyc - last_g, 3);
          last_g = cyc;
        end else begin
          chk("idle_no_grant", 32'(req_ready), 0);
        end
      end else begin
        chk("busy_ready_low", 32'(req_ready), 0);
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid), 0);
        end else begin
          e = sbq[0];
          chk("rsp_id", 32'(rsp_id), e.id);
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (!shown) chk("latency", cyc, e.due);
          shown = 1'b1;
          if (rsp_ready) begin
            void'(sbq.pop_front());
            shown = 1'b0;
            busy = 1'b0;
          end
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
        chk("rsp_missing", 32'(rsp_valid), 1);
      end
    end
  end

  task automatic setp(int i);
    pa[i] = 4'($urandom_range(0, 15));
    pb[i] = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0)
      po[i] = 3'($urandom_range(4, 7));
    else
      po[i] = 3'($urandom_range(0, 3));
  endtask

  task automatic wait_gnt(int i);
    int n = 0;
    while (!gdone[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("grant_timeout", 32'(gdone[i]), 1);
    gdone[i] = 1'b0;
    pv[i] = 1'b0;
  endtask

  task automatic issue(int i, int a, int b, int op);
    pa[i] = 4'(a);
    pb[i] = 4'(b);
    po[i] = 3'(op);
    pv[i] = 1'b1;
    wait_gnt(i);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sbq.size() == 0 && !busy), 1);
  endtask

  task automatic run(int ncyc, int vpct, int rpct);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (gdone[i]) begin
          gdone[i] = 1'b0;
          pv[i] = 1'b0;
        end
        if (!pv[i] && $urandom_range(0, 99) < vpct) begin
          setp(i);
          pv[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < rpct);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    busy = 1'b0;
    shown = 1'b0;
    ptr_m = 0;
    gdone = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    gdone = '0;
    for (int i = 0; i < N; i++) setp(i);
    pv = '1;
    #12;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    pv = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;

    issue(0, 2, 3, 0);
    drain();
    issue(0, 15, 1, 0);
    issue(1, 2, 3, 1);
    issue(0, 10, 12, 2);
    issue(1, 10, 12, 3);
    issue(0, 9, 4, 5);
    drain();

    // Contention: both always valid, consumer always ready
    last_g = -1;
    gapchk = 1'b1;
    for (int i = 0; i < N; i++) begin
      setp(i);
      pv[i] = 1'b1;
    end
    run(24, 100, 100);
    gapchk = 1'b0;
    run(6, 0, 100);
    drain();

    // Backpressure with a competing requester
    rsp_ready = 1'b0;
    issue(0, 7, 8, 0);
    setp(1);
    pv[1] = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    wait_gnt(1);
    drain();

    // Reset in EXEC: pointer must return to 0
    issue(0, 3, 3, 0);
    for (int i = 0; i < N; i++) begin
      setp(i);
      pv[i] = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_exec_ready", 32'(req_ready), 0);
    chk("rst_exec_valid", 32'(rsp_valid), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run(20, 0, 100);
    drain();

    // Reset in RESP, then requester 1 alone
    rsp_ready = 1'b0;
    issue(1, 5, 6, 2);
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(rsp_valid), 0);
    chk("rst_resp_id", 32'(rsp_id), 0);
    chk("rst_resp_result", 32'(rsp_result), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    pa[1] = 4'd4;
    pb[1] = 4'd9;
    po[1] = 3'd0;
    pv[1] = 1'b1;
    rsp_ready = 1'b1;
    run(12, 0, 100);
    drain();

    // Random traffic with random backpressure
    run(400, 60, 60);
    pv = '0;
    rsp_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
